// File: rtl/terminal_pkg.sv
// terminal_pkg
//   Shared definitions for the terminal text buffer:
//   - default screen geometry (columns, rows, cell size in pixels)
//   - ASCII codes with special meaning to the buffer
//   - the write-side FSM state type
//   - a helper that classifies printable codes
package terminal_pkg;

  localparam int DEF_COLS   = 64;
  localparam int DEF_ROWS   = 20;
  localparam int DEF_CHAR_W = 20;
  localparam int DEF_CHAR_H = 36;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_NL       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_CURSOR   = 8'h7F;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_ROW
  } tb_state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/terminal_cell_ram.sv
// terminal_cell_ram
//   Simple dual-port character cell store, 8 bits x DEPTH.
//   Ports:
//     clk    : clock
//     we     : write enable
//     waddr  : write address
//     wdata  : write data (character code)
//     raddr  : read address
//     rdata  : registered read data, one cycle after raddr
//   A read and write to the same address in one cycle returns the old value.
module terminal_cell_ram #(
  parameter int DEPTH  = 1280,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  // NOTE: the array has no reset; the owner clears it by writing every cell,
  // which keeps it mappable onto block RAM.
  logic [7:0] mem [DEPTH];

  // NOTE: non-blocking assignments make the read sample the pre-write value,
  // which is exactly the read-first behaviour the renderer relies on.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/terminal_text_buffer.sv
// terminal_text_buffer
//   Character-cell store for the on-screen terminal, feeding the sprite renderer.
//   Write side: byte codes over valid/ready; cursor tracking; scroll by rotating
//   the top row pointer (stored rows are never moved).
//   Read side: 2-cycle pipeline mapping pixel (hcount, vcount) to the glyph code
//   and pixel origin of the cell underneath.
//   Ports:
//     pixel_clk_in    : clock for all logic
//     rst_in          : synchronous active-high reset
//     char_in         : code to apply
//     char_valid_in   : char_in valid
//     char_ready_out  : buffer accepts char_in this cycle (FSM idle)
//     hcount_in       : pixel x
//     vcount_in       : pixel y
//     char_out        : glyph code of the cell under the pixel (zero-extended)
//     x_out, y_out    : cell origin in pixels
//     cell_valid_out  : pixel lies inside the text area
//     cursor_col_out  : cursor column
//     cursor_row_out  : cursor screen row
//   Build option TERM_CURSOR_BLINK_EN: blinking block cursor overlay.
module terminal_text_buffer
  import terminal_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int CHAR_W = DEF_CHAR_W,
  parameter int CHAR_H = DEF_CHAR_H
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_in,
  input  logic [7:0]              char_in,
  input  logic                    char_valid_in,
  output logic                    char_ready_out,
  input  logic [10:0]             hcount_in,
  input  logic [9:0]              vcount_in,
  output logic [15:0]             char_out,
  output logic [10:0]             x_out,
  output logic [9:0]              y_out,
  output logic                    cell_valid_out,
  output logic [$clog2(COLS)-1:0] cursor_col_out,
  output logic [$clog2(ROWS)-1:0] cursor_row_out
);

  localparam int CELLS  = ROWS * COLS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]    ROWS_EXT  = (ROW_W + 1)'(ROWS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_CCNT = ADDR_W'(COLS - 1);
  localparam logic [10:0]       H_AREA    = 11'(COLS * CHAR_W);
  localparam logic [9:0]        V_AREA    = 10'(ROWS * CHAR_H);

  // Screen row -> physical row under the current scroll offset.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] top,
                                                input logic [ROW_W-1:0] row);
    logic [ROW_W:0] s;
    s = {1'b0, top} + {1'b0, row};
    if (s >= ROWS_EXT) s = s - ROWS_EXT;
    return s[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'(int'(r) * COLS + int'(c));
  endfunction

  tb_state_t state, next_state;

  logic [ADDR_W-1:0] clr_cnt;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [ROW_W-1:0]  top_row;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  // Write-side decode
  logic xfer, is_print, is_nl, is_cr, is_bs, do_nl, scroll;
  logic [ROW_W-1:0] cur_phys;
  logic [ROW_W-1:0] bottom_phys;

  assign xfer        = char_valid_in && char_ready_out;
  assign is_print    = is_printable(char_in);
  assign is_nl       = (char_in == CH_NL);
  assign is_cr       = (char_in == CH_CR);
  assign is_bs       = (char_in == CH_BS);
  // A printable code in the last column writes and then wraps like a newline.
  assign do_nl       = is_nl || (is_print && (cur_col == LAST_COL));
  assign scroll      = xfer && do_nl && (cur_row == LAST_ROW);
  assign cur_phys    = phys_row(top_row, cur_row);
  // After a scroll top_row has advanced, so the row to blank sits just above it.
  assign bottom_phys = (top_row == '0) ? LAST_ROW : top_row - ROW_W'(1);

  // FSM: state register
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state <= CLR_ALL;
    else        state <= next_state;
  end

  // FSM: next state
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      CLR_ALL: if (clr_cnt == LAST_CELL) next_state = IDLE;
      CLR_ROW: if (clr_cnt == LAST_CCNT) next_state = IDLE;
      IDLE:    if (scroll)               next_state = CLR_ROW;
      default:                           next_state = IDLE;
    endcase
  end

  // FSM: outputs (handshake and RAM write port)
  always_comb begin
    char_ready_out = 1'b0;
    ram_we         = 1'b0;
    ram_waddr      = '0;
    ram_wdata      = CH_SPACE;
    unique case (state)
      CLR_ALL: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt;
      end
      CLR_ROW: begin
        ram_we    = 1'b1;
        ram_waddr = cell_addr(bottom_phys, clr_cnt[COL_W-1:0]);
      end
      IDLE: begin
        char_ready_out = 1'b1;
        if (xfer) begin
          if (is_print) begin
            ram_we    = 1'b1;
            ram_waddr = cell_addr(cur_phys, cur_col);
            ram_wdata = char_in;
          end else if (is_bs && (cur_col != '0)) begin
            ram_we    = 1'b1;
            ram_waddr = cell_addr(cur_phys, cur_col - COL_W'(1));
          end
        end
      end
      default: ;
    endcase
  end

  // Cursor, scroll pointer and clear counter
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      cur_col <= '0;
      cur_row <= '0;
      top_row <= '0;
      clr_cnt <= '0;
    end else begin
      if ((state == IDLE) || (next_state != state)) clr_cnt <= '0;
      else                                          clr_cnt <= clr_cnt + ADDR_W'(1);

      if (xfer) begin
        if (do_nl) begin
          cur_col <= '0;
          if (cur_row != LAST_ROW)  cur_row <= cur_row + ROW_W'(1);
          else if (top_row == LAST_ROW) top_row <= '0;
          else                      top_row <= top_row + ROW_W'(1);
        end else if (is_print) begin
          cur_col <= cur_col + COL_W'(1);
        end else if (is_cr) begin
          cur_col <= '0;
        end else if (is_bs && (cur_col != '0)) begin
          cur_col <= cur_col - COL_W'(1);
        end
      end
    end
  end

  assign cursor_col_out = cur_col;
  assign cursor_row_out = cur_row;

  // Read pipeline, stage 1: pixel -> cell (constant divides), physical address
  logic [10:0]       h_col;
  logic [9:0]        v_row;
  logic              in_area;
  logic [COL_W-1:0]  rd_col;
  logic [ROW_W-1:0]  rd_row;

  assign h_col   = hcount_in / 11'(CHAR_W);
  assign v_row   = vcount_in / 10'(CHAR_H);
  assign in_area = (hcount_in < H_AREA) && (vcount_in < V_AREA);
  assign rd_col  = h_col[COL_W-1:0];
  assign rd_row  = v_row[ROW_W-1:0];

  logic [ADDR_W-1:0] s1_addr;
  logic [10:0]       s1_x, s2_x;
  logic [9:0]        s1_y, s2_y;
  logic              s1_valid, s2_valid;
  // Live flags hold char_out at 0 until real read data reaches stage 2.
  logic              s1_live, s2_live;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      s1_addr  <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_valid <= 1'b0;
      s1_live  <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
      s2_valid <= 1'b0;
      s2_live  <= 1'b0;
    end else begin
      s1_addr  <= in_area ? cell_addr(phys_row(top_row, rd_row), rd_col) : '0;
      s1_x     <= h_col * 11'(CHAR_W);
      s1_y     <= v_row * 10'(CHAR_H);
      s1_valid <= in_area;
      s1_live  <= 1'b1;
      s2_x     <= s1_x;
      s2_y     <= s1_y;
      s2_valid <= s1_valid;
      s2_live  <= s1_live;
    end
  end

  terminal_cell_ram #(
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (pixel_clk_in),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (s1_addr),
    .rdata (ram_rdata)
  );

  logic cursor_hit;

`ifdef TERM_CURSOR_BLINK_EN
  logic [24:0]      blink_cnt;
  logic             blink_phase;
  logic [COL_W-1:0] s1_col, s2_col;
  logic [ROW_W-1:0] s1_row, s2_row;

  // Phase flips each time the 25-bit counter wraps.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      s1_col      <= '0;
      s1_row      <= '0;
      s2_col      <= '0;
      s2_row      <= '0;
    end else begin
      blink_cnt <= blink_cnt + 25'd1;
      if (&blink_cnt) blink_phase <= ~blink_phase;
      s1_col <= rd_col;
      s1_row <= rd_row;
      s2_col <= s1_col;
      s2_row <= s1_row;
    end
  end

  assign cursor_hit = blink_phase && (s2_col == cur_col) && (s2_row == cur_row);
`else
  assign cursor_hit = 1'b0;
`endif

  // Stage 2 output select
  always_comb begin
    if (!s2_live)       char_out = '0;
    else if (!s2_valid) char_out = {8'h00, CH_SPACE};
    else if (cursor_hit) char_out = {8'h00, CH_CURSOR};
    else                char_out = {8'h00, ram_rdata};
  end

  assign x_out          = s2_x;
  assign y_out          = s2_y;
  assign cell_valid_out = s2_valid;

endmodule

// File: tb/tb_terminal_text_buffer.sv
// tb_terminal_text_buffer
//   Scoreboard bench for terminal_text_buffer. The reference model keeps the
//   visible screen as a plain 2-D array indexed by screen row; a scroll shifts
//   the rows up and blanks the last one. Probes push their expected response
//   into a queue; a monitor pops and compares when the output arrives.
module tb_terminal_text_buffer;

  localparam int COLS = 64;
  localparam int ROWS = 20;
  localparam int CW   = 20;
  localparam int CH   = 36;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid_in = 1'b0;
  logic        char_ready_out;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic [15:0] char_out;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        cell_valid_out;
  logic [5:0]  cursor_col_out;
  logic [4:0]  cursor_row_out;

  terminal_text_buffer dut (
    .pixel_clk_in   (pixel_clk_in),
    .rst_in         (rst_in),
    .char_in        (char_in),
    .char_valid_in  (char_valid_in),
    .char_ready_out (char_ready_out),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .char_out       (char_out),
    .x_out          (x_out),
    .y_out          (y_out),
    .cell_valid_out (cell_valid_out),
    .cursor_col_out (cursor_col_out),
    .cursor_row_out (cursor_row_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] scr [ROWS][COLS];
  int m_col, m_row;
  bit blink_forced = 1'b0;

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
    m_col = 0;
    m_row = 0;
  endfunction

  function automatic void model_nl();
    m_col = 0;
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
    end
  endfunction

  function automatic void model_apply(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      scr[m_row][m_col] = c;
      if (m_col == COLS - 1) model_nl();
      else m_col++;
    end else if (c == 8'h0A) model_nl();
    else if (c == 8'h0D) m_col = 0;
    else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        scr[m_row][m_col] = 8'h20;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] ch;
    logic [10:0] x;
    logic [9:0]  y;
    logic        v;
  } exp_t;

  exp_t exp_q[$];
  logic probe_tag = 1'b0;
  logic tag_d1 = 1'b0;
  logic tag_d2 = 1'b0;

  always @(posedge pixel_clk_in) begin
    tag_d1 <= probe_tag;
    tag_d2 <= tag_d1;
  end

  always @(negedge pixel_clk_in) begin : monitor
    exp_t e;
    if (tag_d2) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL probe_queue: output arrived with no expected entry queued");
      end else begin
        e = exp_q.pop_front();
        check("char_out", 32'(char_out), 32'(e.ch));
        check("cell_valid_out", 32'(cell_valid_out), 32'(e.v));
        if (e.v) begin
          check("x_out", 32'(x_out), 32'(e.x));
          check("y_out", 32'(y_out), 32'(e.y));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic probe(input int h, input int v);
    exp_t e;
    int c, r;
    @(negedge pixel_clk_in);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    if (h < COLS * CW && v < ROWS * CH) begin
      c = h / CW;
      r = v / CH;
      e.v = 1'b1;
      e.x = 11'(c * CW);
      e.y = 10'(r * CH);
      e.ch = (blink_forced && c == m_col && r == m_row) ? 16'h007F : {8'h00, scr[r][c]};
    end else begin
      e.v = 1'b0;
      e.x = '0;
      e.y = '0;
      e.ch = 16'h0020;
    end
    exp_q.push_back(e);
    probe_tag = 1'b1;
    @(posedge pixel_clk_in);
    #1 probe_tag = 1'b0;
  endtask

  task automatic probe_cell(input int c, input int r);
    probe(c * CW + int'($urandom_range(0, CW - 1)), r * CH + int'($urandom_range(0, CH - 1)));
  endtask

  task automatic drain();
    repeat (4) @(negedge pixel_clk_in);
  endtask

  task automatic send(input logic [7:0] c);
    int guard = 0;
    @(negedge pixel_clk_in);
    char_in = c;
    char_valid_in = 1'b1;
    while (!char_ready_out && guard < 5000) begin
      @(negedge pixel_clk_in);
      guard++;
    end
    if (!char_ready_out) begin
      check("ready_timeout", 32'(char_ready_out), 32'd1);
      char_valid_in = 1'b0;
    end else begin
      @(posedge pixel_clk_in);
      model_apply(c);
      @(negedge pixel_clk_in);
      char_valid_in = 1'b0;
    end
  endtask

  task automatic check_cursor(input string name);
    check({name, "_col"}, 32'(cursor_col_out), 32'(m_col));
    check({name, "_row"}, 32'(cursor_row_out), 32'(m_row));
  endtask

  task automatic count_busy(input string name, input int required);
    int n = 0;
    while (!char_ready_out && n < 3000) begin
      n++;
      @(negedge pixel_clk_in);
    end
    check(name, 32'(n), 32'(required));
  endtask

  task automatic do_reset();
    @(negedge pixel_clk_in);
    rst_in = 1'b1;
    char_valid_in = 1'b0;
    @(negedge pixel_clk_in);
    rst_in = 1'b0;
    model_clear();
    check("rst_char_out", 32'(char_out), 32'd0);
    check("rst_x_out", 32'(x_out), 32'd0);
    check("rst_y_out", 32'(y_out), 32'd0);
    check("rst_cell_valid", 32'(cell_valid_out), 32'd0);
    check("rst_ready", 32'(char_ready_out), 32'd0);
    check_cursor("rst_cursor");
    count_busy("clr_all_busy_cycles", 1280);
  endtask

  function automatic logic [7:0] rand_code();
    int p = int'($urandom_range(0, 99));
    if (p < 80) return 8'($urandom_range(32, 126));
    if (p < 88) return 8'h0A;
    if (p < 92) return 8'h0D;
    if (p < 96) return 8'h08;
    return 8'($urandom_range(127, 255));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    model_clear();
    repeat (3) @(negedge pixel_clk_in);

    // Reset and full clear
    do_reset();
    probe_cell(0, 0);
    probe_cell(COLS - 1, ROWS - 1);
    for (int i = 0; i < 30; i++)
      probe_cell(int'($urandom_range(0, COLS - 1)), int'($urandom_range(0, ROWS - 1)));
    drain();

    // 'A','B' then the fixed probe point
    send(8'h41);
    send(8'h42);
    check_cursor("after_AB");
    probe(25, 5);
    drain();

    // Fill out the first row to wrap onto row 1
    for (int i = 0; i < 62; i++) send(8'($urandom_range(32, 126)));
    check_cursor("after_64");
    send(8'h08);
    check_cursor("bs_at_col0");
    send(8'h43);
    send(8'h08);
    check_cursor("after_C_bs");
    probe_cell(0, 1);
    probe_cell(1, 0);
    drain();

    // Random code stream with interleaved probes
    for (int i = 0; i < 400; i++) begin
      send(rand_code());
      if (i % 25 == 24) begin
        check_cursor("rand_cursor");
        for (int k = 0; k < 4; k++)
          probe(int'($urandom_range(0, 1400)), int'($urandom_range(0, 800)));
        drain();
      end
    end

    // Directed scroll from the bottom row
    while (m_row != ROWS - 1) send(8'h0A);
    send(8'h0D);
    for (int i = 0; i < 10; i++) send(8'h61 + 8'(i));
    send(8'h0A);
    count_busy("clr_row_busy_cycles", 64);
    check_cursor("after_scroll");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) probe_cell(c, r);
    drain();

    // Outside and edge of the text area
    probe(1290, 5);
    probe(5, 725);
    probe(1280, 0);
    probe(0, 720);
    probe(1279, 719);
    probe(2047, 1023);
    drain();

    // Reset in the middle of a row clear
    send(8'h0A);
    repeat (10) @(negedge pixel_clk_in);
    check("mid_clr_row_ready", 32'(char_ready_out), 32'd0);
    do_reset();
    for (int i = 0; i < 20; i++)
      probe_cell(int'($urandom_range(0, COLS - 1)), int'($urandom_range(0, ROWS - 1)));
    drain();
    send(8'h5A);
    send(8'h79);
    check_cursor("post_reset_write");
    probe_cell(0, 0);
    probe_cell(1, 0);
    probe_cell(2, 0);
    drain();

`ifdef TERM_CURSOR_BLINK_EN
    force dut.blink_phase = 1'b1;
    blink_forced = 1'b1;
    probe_cell(m_col, m_row);
    probe_cell((m_col < COLS - 1) ? m_col + 1 : m_col - 1, m_row);
    probe_cell(0, 0);
    drain();
    release dut.blink_phase;
    blink_forced = 1'b0;
`endif

    check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
